imem_loader_ctrl: RTL and testbench
===================================

Name: imem_loader_ctrl

Overview:
- Sequences the program-load phase of the pipelined CPU.
- Collects bytes from the serial receiver, packs them into 32-bit little-endian words and writes them to consecutive instruction-memory addresses. Raises write_done when the image is complete.
- Arbitrates the single memory write/address port between the loader (load phase, write=1) and the CPU (run phase, mode=1).

Parameters:
ADDR_W, 10, memory word-address width
NUM_WORDS, 256, words in a full image; write_done asserts after this many commits (1..2**ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
write  in  1  load phase enable from the mode FSM
mode  in  1  run phase from the mode FSM
rx_valid  in  1  receiver byte available
rx_data  in  8  receiver byte
rx_ready  out  1  loader accepts byte this cycle
cpu_addr  in  ADDR_W  CPU memory word address
cpu_wdata  in  32  CPU write data
cpu_we  in  1  CPU write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_we  out  1  memory write enable
cpu_grant  out  1  CPU currently owns the memory port
write_done  out  1  full image committed (sticky)
word_count  out  ADDR_W+1  words committed so far

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, byte_idx=0, word buffer=0, load_addr=0, word_count=0, write_done=0. Reset has priority over every other event, including mid-word and mid-commit; partial words are discarded.
- States: IDLE, COLLECT, COMMIT, DONE.
- IDLE:
  - write=1 -> COLLECT; clear byte_idx, load_addr and word_count.
  - Otherwise stay.
- COLLECT:
  - rx_ready=1.
  - Byte handshake is rx_valid && rx_ready: place rx_data at buffer[8*byte_idx+:8] and increment byte_idx. Byte 0 is bits 7:0.
  - When the accepted byte has byte_idx==3 -> COMMIT next cycle; byte_idx wraps to 0.
  - write=0 while in COLLECT -> IDLE. Partial bytes are discarded; no memory write occurs.
- COMMIT (exactly one cycle):
  - rx_ready=0; bytes presented this cycle are not consumed.
  - mem_we=1, mem_addr=load_addr, mem_wdata=buffer.
  - At the edge: load_addr+1 and word_count+1.
  - If the new word_count == NUM_WORDS -> DONE; else -> COLLECT.
  - A write drop during COMMIT does not cancel the commit in progress; the next state then evaluates write as in COLLECT.
- Latency: the 4th byte is accepted at edge N; mem_we is high for the cycle following edge N; the next byte is accepted no earlier than edge N+2.
- DONE:
  - write_done=1, held until rst.
  - rx_ready=0.
  - write toggling is ignored; there is no reload without reset.
  - load_addr is saturated at NUM_WORDS and never wraps.
- Port mux (combinational, zero latency):
  - State COMMIT -> loader drives mem_*; cpu_grant=0.
  - Else if mode=1 -> mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we; cpu_grant=1.
  - Else mem_addr=0, mem_wdata=0, mem_we=0, cpu_grant=0.
  - Simultaneous mode=1 and COMMIT: the loader wins; the CPU write that cycle is dropped (cpu_grant=0 tells it so).
- Outputs: write_done and word_count are registered; rx_ready, cpu_grant and mem_* decode from state and inputs.

Test Plan:
- Reset mid-word: write=1, send 0x11,0x22, assert rst for 1 cycle -> word_count=0, write_done=0, no mem_we pulse, state IDLE.
- Single-word pack: NUM_WORDS=2, write=1, send 0x78,0x56,0x34,0x12 back-to-back -> one mem_we pulse with mem_addr=0, mem_wdata=0x12345678, one cycle after the 4th byte; rx_ready=0 that cycle; word_count=1.
- Full image: NUM_WORDS=2, send 8 bytes with random rx_valid gaps -> commits at addr 0 and 1; write_done=1 the cycle after the 2nd commit and stays 1; rx_ready=0 thereafter.
- Abort: write=1, send 3 bytes, drop write -> IDLE, no write. Re-raise write and send 4 bytes -> first commit at mem_addr=0 containing only the new bytes.
- Run passthrough: after DONE, mode=1, cpu_addr=0x3F, cpu_wdata=0xDEADBEEF, cpu_we=1 -> mem_* equal the CPU values in the same cycle; cpu_grant=1.
- Collision: force mode=1 during COMMIT with cpu_we=1 -> mem_* carry loader values, cpu_grant=0; with mode=0 and write=0 outside COMMIT -> mem_we=0.

Source files
------------

// File: rtl/imem_loader_ctrl_if.sv
// Purpose: bundles the receiver byte stream, CPU memory request and shared memory port.
// Latency: none, wires only.
// Backpressure: rx_ready from the loader throttles the receiver; cpu_grant tells the CPU whether its access landed.
interface imem_loader_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_grant;

  // Environment side: receiver and CPU drive requests, observe the memory port.
  modport master (
    output rx_valid, rx_data, cpu_addr, cpu_wdata, cpu_we,
    input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_grant
  );

  // Loader side: consumes requests, owns the memory port mux.
  modport slave (
    input  rx_valid, rx_data, cpu_addr, cpu_wdata, cpu_we,
    output rx_ready, mem_addr, mem_wdata, mem_we, cpu_grant
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Purpose: packs received bytes into little-endian words, writes them to consecutive imem addresses, then hands the port to the CPU.
// Latency: memory write is issued the cycle after the 4th byte; port mux is combinational.
// Backpressure: rx_ready only in COLLECT, so one byte-slot bubble per word; CPU is blocked (cpu_grant=0) during a loader commit.
module imem_loader_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              mode,
  imem_loader_ctrl_if.slave bus,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] NUM_W = (ADDR_W+1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      byte_idx;
  logic [31:0]     buffer;
  logic [ADDR_W:0] load_addr;
  logic [ADDR_W:0] count_inc;
  logic            start;
  logic            byte_fire;
  logic            abort;
  logic            commit;

  assign count_inc = word_count + 1'b1;

  // State register; reset returns to IDLE from anywhere, dropping any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    byte_fire = 1'b0;
    abort     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (write) begin
          state_nxt = COLLECT;
          start     = 1'b1;
        end
      end
      COLLECT: begin
        // Dropping write wins over a byte arriving the same cycle: the word is abandoned.
        if (!write) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (bus.rx_valid) begin
          byte_fire = 1'b1;
          if (byte_idx == 2'd3) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit = 1'b1;
        // The commit always completes; write is only re-examined for where to go next.
        if (count_inc == NUM_W) begin
          state_nxt = DONE;
        end else if (!write) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = COLLECT;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte packing, load address / word counters and the sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      buffer     <= 32'd0;
      load_addr  <= '0;
      word_count <= '0;
      write_done <= 1'b0;
    end else begin
      if (start) begin
        byte_idx   <= 2'd0;
        load_addr  <= '0;
        word_count <= '0;
      end
      if (abort) begin
        byte_idx <= 2'd0;
      end
      if (byte_fire) begin
        buffer[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
        byte_idx                        <= byte_idx + 2'd1;
      end
      // At most NUM_WORDS commits happen before DONE, so load_addr stops at NUM_WORDS.
      if (commit) begin
        load_addr  <= load_addr + 1'b1;
        word_count <= count_inc;
      end
      if (state_nxt == DONE) begin
        write_done <= 1'b1;
      end
    end
  end

  // Shared memory port: a loader commit beats the CPU, otherwise run mode passes the CPU through.
  always_comb begin
    bus.rx_ready  = (state == COLLECT);
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    bus.mem_we    = 1'b0;
    bus.cpu_grant = 1'b0;
    if (state == COMMIT) begin
      bus.mem_addr  = load_addr[ADDR_W-1:0];
      bus.mem_wdata = buffer;
      bus.mem_we    = 1'b1;
    end else if (mode) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we;
      bus.cpu_grant = 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Purpose: self-checking bench for imem_loader_ctrl with a commit scoreboard and a port-mux vector table.
// Latency: checks commit one cycle after the 4th byte and write_done one cycle after the last commit.
// Backpressure: byte sender waits on rx_ready with a bounded cycle budget.
module tb_imem_loader_ctrl;
  localparam int ADDR_W    = 10;
  localparam int NUM_WORDS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            write;
  logic            mode;
  logic            write_done;
  logic [ADDR_W:0] word_count;

  imem_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader_ctrl #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .mode       (mode),
    .bus        (bus),
    .write_done (write_done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] ca;
    logic [31:0]       cd;
    logic              cwe;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ed;
    logic              ewe;
    logic              eg;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[5];
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   n_commits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) break;
    end
    if (w == 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_ready_timeout: got no rx_ready expected accept of %0h", b);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input bit rnd);
    exp_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      send_byte(data[8*i +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  // Scoreboard side: every loader commit on the memory port must match the next queued word.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.mem_we === 1'b1 && bus.cpu_grant === 1'b0) begin
      n_commits++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_commit: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb_q.pop_front();
        check("commit_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("commit_data", 64'(bus.mem_wdata), 64'(e.data));
        check("commit_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 10'h03F, 32'hDEADBEEF, 1'b1, 10'h03F, 32'hDEADBEEF, 1'b1, 1'b1};
    vt[1] = '{1'b1, 10'h155, 32'h00000000, 1'b0, 10'h155, 32'h00000000, 1'b0, 1'b1};
    vt[2] = '{1'b0, 10'h03F, 32'hDEADBEEF, 1'b1, 10'h000, 32'h00000000, 1'b0, 1'b0};
    vt[3] = '{1'b1, 10'h3FF, 32'hFFFFFFFF, 1'b1, 10'h3FF, 32'hFFFFFFFF, 1'b1, 1'b1};
    vt[4] = '{1'b0, 10'h2AA, 32'h12345678, 1'b0, 10'h000, 32'h00000000, 1'b0, 1'b0};

    rst           = 1'b1;
    write         = 1'b0;
    mode          = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_word_count", 64'(word_count), 64'd0);
    check("reset_write_done", 64'(write_done), 64'd0);
    check("reset_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("reset_mem_we", 64'(bus.mem_we), 64'd0);
    check("reset_cpu_grant", 64'(bus.cpu_grant), 64'd0);

    // Reset in the middle of a word: partial bytes vanish, no memory write.
    @(posedge clk);
    #1;
    write = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst   = 1'b1;
    write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midword_word_count", 64'(word_count), 64'd0);
    check("midword_write_done", 64'(write_done), 64'd0);
    check("midword_idle_rx_ready", 64'(bus.rx_ready), 64'd0);

    // Abort after three bytes, then a clean word that holds only the new bytes.
    @(posedge clk);
    #1;
    write = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    write = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("abort_word_count", 64'(word_count), 64'd0);
    @(posedge clk);
    #1;
    write = 1'b1;
    @(posedge clk);
    #1;
    // CPU hammers the port while the loader collects and commits.
    mode          = 1'b1;
    bus.cpu_addr  = 10'h03F;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.cpu_we    = 1'b1;
    send_word(10'h000, 32'h12345678, 1'b0);
    @(negedge clk);
    check("pack_mem_we", 64'(bus.mem_we), 64'd1);
    check("pack_mem_addr", 64'(bus.mem_addr), 64'h000);
    check("pack_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
    check("collision_cpu_grant", 64'(bus.cpu_grant), 64'd0);
    check("pack_rx_ready", 64'(bus.rx_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pack_word_count", 64'(word_count), 64'd1);
    check("pack_write_done", 64'(write_done), 64'd0);
    check("after_commit_cpu_grant", 64'(bus.cpu_grant), 64'd1);
    check("after_commit_mem_addr", 64'(bus.mem_addr), 64'h03F);
    mode       = 1'b0;
    bus.cpu_we = 1'b0;

    // Last word of the image with random byte gaps.
    send_word(10'h001, 32'hCAFEF00D, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_write_done", 64'(write_done), 64'd1);
    check("full_word_count", 64'(word_count), 64'd2);

    // DONE ignores write toggling and never accepts bytes.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      write = ~write;
      @(negedge clk);
      check("done_hold_write_done", 64'(write_done), 64'd1);
      check("done_hold_rx_ready", 64'(bus.rx_ready), 64'd0);
      check("done_hold_word_count", 64'(word_count), 64'd2);
    end
    bus.rx_valid = 1'b0;
    write        = 1'b0;

    // Run-phase passthrough vectors, checked in the same cycle they are applied.
    for (int i = 0; i < 5; i++) begin
      mode          = vt[i].mode;
      bus.cpu_addr  = vt[i].ca;
      bus.cpu_wdata = vt[i].cd;
      bus.cpu_we    = vt[i].cwe;
      #1;
      check("vec_mem_addr", 64'(bus.mem_addr), 64'(vt[i].ea));
      check("vec_mem_wdata", 64'(bus.mem_wdata), 64'(vt[i].ed));
      check("vec_mem_we", 64'(bus.mem_we), 64'(vt[i].ewe));
      check("vec_cpu_grant", 64'(bus.cpu_grant), 64'(vt[i].eg));
      @(negedge clk);
    end
    mode       = 1'b0;
    bus.cpu_we = 1'b0;

    // Only reset leaves DONE.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("done_reset_write_done", 64'(write_done), 64'd0);
    check("done_reset_word_count", 64'(word_count), 64'd0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("commit_total", 64'(n_commits), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
